// File: rtl/io_display_pkg.sv
// Shared types and constants for the decimal seven-segment display block.
// dd_adjust is the shift-and-add-3 correction step used by the binary-to-BCD engine.
package io_display_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        UPD  = 2'd2
    } state_t;

    localparam int unsigned DIGITS    = 6;
    localparam int unsigned CONV_BITS = 20;
    localparam int unsigned BCD_BITS  = 4 * DIGITS;
    localparam logic [31:0] OVF_LIMIT = 32'd1_000_000;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    function automatic logic [BCD_BITS-1:0] dd_adjust(input logic [BCD_BITS-1:0] bcd);
        logic [BCD_BITS-1:0] r;
        r = bcd;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (r[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = r[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/io_hex_display_if.sv
// Bundle between a CPU output port (master) and the hex display block (slave).
interface io_hex_display_if;

    logic [31:0] value;
    logic [6:0]  hex0;
    logic [6:0]  hex1;
    logic [6:0]  hex2;
    logic [6:0]  hex3;
    logic [6:0]  hex4;
    logic [6:0]  hex5;
    logic        busy;
    logic        ovf;

    modport master (
        output value,
        input  hex0, hex1, hex2, hex3, hex4, hex5, busy, ovf
    );

    modport slave (
        input  value,
        output hex0, hex1, hex2, hex3, hex4, hex5, busy, ovf
    );

endinterface

// File: rtl/io_hex_display_seg7_decode.sv
// Combinational BCD digit to active-low segment pattern {g,f,e,d,c,b,a}.
// Non-decimal codes never occur from the converter; they render blank.
module seg7_decode
    import io_display_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (digit_i)
            4'd0:    seg_o = 7'b1000000;
            4'd1:    seg_o = 7'b1111001;
            4'd2:    seg_o = 7'b0100100;
            4'd3:    seg_o = 7'b0110000;
            4'd4:    seg_o = 7'b0011001;
            4'd5:    seg_o = 7'b0010010;
            4'd6:    seg_o = 7'b0000010;
            4'd7:    seg_o = 7'b1111000;
            4'd8:    seg_o = 7'b0000000;
            4'd9:    seg_o = 7'b0010000;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/io_hex_display.sv
// Shows a 32-bit CPU output value in decimal on six digits, converting with a
// one-bit-per-clock double-dabble engine and updating all digits together.
module io_hex_display
    import io_display_pkg::*;
#(
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic        clock,
    input  logic        resetn,
    io_hex_display_if.slave bus
);

    localparam logic [6:0] SEG_LEAD = BLANK_LEADING ? SEG_BLANK : SEG_ZERO;
    localparam logic [DIGITS-1:0][6:0] HEX_RST = {{(DIGITS-1){SEG_LEAD}}, SEG_ZERO};

    state_t                    state_q, state_d;
    logic [31:0]               last_q, last_d;
    logic [31:0]               cap_q, cap_d;
    logic [CONV_BITS-1:0]      shadow_q, shadow_d;
    logic [BCD_BITS-1:0]       bcd_q, bcd_d, bcd_adj;
    logic [4:0]                cnt_q, cnt_d;
    logic                      povf_q, povf_d;
    logic                      ovf_q, ovf_d;
    logic [DIGITS-1:0][6:0]    hex_q, hex_d;
    logic [DIGITS-1:0][6:0]    dec;
    logic [DIGITS-1:0][6:0]    disp;
    logic                      lead;
    int unsigned               idx;

    for (genvar g = 0; g < DIGITS; g++) begin : g_dec
        seg7_decode u_dec (
            .digit_i (bcd_q[4*g +: 4]),
            .seg_o   (dec[g])
        );
    end

    assign bcd_adj = dd_adjust(bcd_q);

    // Walk from the top digit down; blanking stops at the first nonzero digit.
    always_comb begin
        disp = dec;
        lead = BLANK_LEADING;
        idx  = 0;
        for (int unsigned i = 0; i < DIGITS - 1; i++) begin
            idx = DIGITS - 1 - i;
            if (bcd_q[4*idx +: 4] != 4'd0) begin
                lead = 1'b0;
            end
            if (lead) begin
                disp[idx] = SEG_BLANK;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        cap_d    = cap_q;
        shadow_d = shadow_q;
        bcd_d    = bcd_q;
        cnt_d    = cnt_q;
        povf_d   = povf_q;
        ovf_d    = ovf_q;
        hex_d    = hex_q;
        case (state_q)
            IDLE: begin
                if (bus.value != last_q) begin
                    cap_d = bus.value;
                    if (bus.value >= OVF_LIMIT) begin
                        povf_d  = 1'b1;
                        state_d = UPD;
                    end else begin
                        povf_d   = 1'b0;
                        shadow_d = bus.value[CONV_BITS-1:0];
                        bcd_d    = '0;
                        cnt_d    = '0;
                        state_d  = CONV;
                    end
                end
            end
            CONV: begin
                {bcd_d, shadow_d} = {bcd_adj, shadow_q} << 1;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'(CONV_BITS - 1)) begin
                    state_d = UPD;
                end
            end
            UPD: begin
                hex_d   = povf_q ? {DIGITS{SEG_DASH}} : disp;
                last_d  = cap_q;
                ovf_d   = povf_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q  <= IDLE;
            last_q   <= '0;
            cap_q    <= '0;
            shadow_q <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            povf_q   <= 1'b0;
            ovf_q    <= 1'b0;
            hex_q    <= HEX_RST;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            cap_q    <= cap_d;
            shadow_q <= shadow_d;
            bcd_q    <= bcd_d;
            cnt_q    <= cnt_d;
            povf_q   <= povf_d;
            ovf_q    <= ovf_d;
            hex_q    <= hex_d;
        end
    end

    assign bus.hex0 = hex_q[0];
    assign bus.hex1 = hex_q[1];
    assign bus.hex2 = hex_q[2];
    assign bus.hex3 = hex_q[3];
    assign bus.hex4 = hex_q[4];
    assign bus.hex5 = hex_q[5];
    assign bus.busy = (state_q != IDLE);
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_io_hex_display.sv
// Directed bench for io_hex_display: one instance with leading-zero blanking,
// one without, both fed the same value stream.
module tb_io_hex_display;

    logic clk   = 1'b0;
    logic rstn  = 1'b0;

    always #5 clk = ~clk;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SB = 7'b1111111;
    localparam logic [6:0] SD = 7'b0111111;

    io_hex_display_if bus_bl ();
    io_hex_display_if bus_nb ();

    io_hex_display dut_bl (
        .clock  (clk),
        .resetn (rstn),
        .bus    (bus_bl)
    );

    io_hex_display #(.BLANK_LEADING(1'b0)) dut_nb (
        .clock  (clk),
        .resetn (rstn),
        .bus    (bus_nb)
    );

    logic [41:0] disp_bl, disp_nb;
    assign disp_bl = {bus_bl.hex5, bus_bl.hex4, bus_bl.hex3, bus_bl.hex2, bus_bl.hex1, bus_bl.hex0};
    assign disp_nb = {bus_nb.hex5, bus_nb.hex4, bus_nb.hex3, bus_nb.hex2, bus_nb.hex1, bus_nb.hex0};

    int n_checks = 0;
    int n_fails  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_value(input logic [31:0] v);
        bus_bl.value = v;
        bus_nb.value = v;
    endtask

    // Counts busy cycles until busy drops after having been seen high; bounded.
    task automatic run_conv(output int n);
        n = 0;
        for (int i = 0; i < 80; i++) begin
            step();
            if (bus_bl.busy) n++;
            else if (n > 0) break;
        end
    endtask

    int  n, m;
    logic busy_seen;

    initial begin
        set_value(32'd0);
        rstn = 1'b0;
        repeat (3) step();
        chk("rst_disp_bl", disp_bl, {SB, SB, SB, SB, SB, S0});
        chk("rst_disp_nb", disp_nb, {6{S0}});
        chk("rst_busy", bus_bl.busy, 1'b0);
        chk("rst_ovf", bus_bl.ovf, 1'b0);

        rstn = 1'b1;
        busy_seen = 1'b0;
        repeat (5) begin
            step();
            busy_seen = busy_seen | bus_bl.busy | bus_nb.busy;
        end
        chk("idle_no_conv", busy_seen, 1'b0);
        chk("idle_disp_bl", disp_bl, {SB, SB, SB, SB, SB, S0});

        set_value(32'd123456);
        run_conv(n);
        chk("conv_123456_busy", n, 21);
        chk("disp_123456_bl", disp_bl, {S1, S2, S3, S4, S5, S6});
        chk("disp_123456_nb", disp_nb, {S1, S2, S3, S4, S5, S6});
        chk("ovf_123456", bus_bl.ovf, 1'b0);

        set_value(32'd42);
        run_conv(n);
        chk("conv_42_busy", n, 21);
        chk("disp_42_bl", disp_bl, {SB, SB, SB, SB, S4, S2});
        chk("disp_42_nb", disp_nb, {S0, S0, S0, S0, S4, S2});

        set_value(32'd999999);
        run_conv(n);
        chk("conv_999999_busy", n, 21);
        chk("disp_999999", disp_bl, {6{S9}});
        chk("ovf_999999", bus_bl.ovf, 1'b0);

        set_value(32'd1000000);
        step();
        chk("ovf_busy_1", bus_bl.busy, 1'b1);
        chk("ovf_not_yet", bus_bl.ovf, 1'b0);
        chk("disp_before_ovf", disp_bl, {6{S9}});
        step();
        chk("ovf_set", bus_bl.ovf, 1'b1);
        chk("ovf_busy_0", bus_bl.busy, 1'b0);
        chk("disp_ovf_bl", disp_bl, {6{SD}});
        chk("disp_ovf_nb", disp_nb, {6{SD}});
        busy_seen = 1'b0;
        repeat (4) begin
            step();
            busy_seen = busy_seen | bus_bl.busy;
        end
        chk("ovf_no_reconv", busy_seen, 1'b0);
        chk("ovf_held", bus_bl.ovf, 1'b1);

        set_value(32'd5);
        run_conv(n);
        chk("conv_5_busy", n, 21);
        chk("ovf_cleared", bus_bl.ovf, 1'b0);
        chk("disp_5_bl", disp_bl, {SB, SB, SB, SB, SB, S5});

        set_value(32'd111111);
        n = 0;
        repeat (10) begin
            step();
            if (bus_bl.busy) n++;
        end
        chk("mid_busy", bus_bl.busy, 1'b1);
        set_value(32'd222222);
        run_conv(m);
        chk("conv_111111_busy", n + m, 21);
        chk("disp_111111", disp_bl, {6{S1}});
        run_conv(m);
        chk("conv_222222_busy", m, 21);
        chk("disp_222222", disp_bl, {6{S2}});

        set_value(32'd654321);
        repeat (7) step();
        chk("pre_reset_busy", bus_bl.busy, 1'b1);
        rstn = 1'b0;
        step();
        chk("midrst_busy", bus_bl.busy, 1'b0);
        chk("midrst_ovf", bus_bl.ovf, 1'b0);
        chk("midrst_disp_bl", disp_bl, {SB, SB, SB, SB, SB, S0});
        chk("midrst_disp_nb", disp_nb, {6{S0}});
        rstn = 1'b1;
        run_conv(n);
        chk("conv_654321_busy", n, 21);
        chk("disp_654321_bl", disp_bl, {S6, S5, S4, S3, S2, S1});
        chk("disp_654321_nb", disp_nb, {S6, S5, S4, S3, S2, S1});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
